// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style control FSM.
// The state register and the latched opcode are the only storage. Outputs are
// decoded from the current state. A few outputs are also qualified by an input
// in the same cycle: the FETCH IR/PC write and the MEMWR completion wait for
// mem_ready, and the BRANCH PC write depends on zero.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [4:0] alu_op,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic       mem_to_reg,
    output logic [3:0] state,
    output logic       illegal_op,
    output logic       instr_done
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_RWB    = 4'd7,
        S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_IEXEC  = 4'd10, S_IWB    = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t     st;
    logic [5:0] op_q;

    assign state = st;

    // State sequencing; opcode captured in DECODE for later states. Reset abandons any memory wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st   <= S_FETCH;
            op_q <= 6'b000000;
        end else begin
            case (st)
                S_FETCH:  if (mem_ready) st <= S_DECODE;
                S_DECODE: begin
                    op_q <= opcode;
                    case (opcode)
                        OP_LW, OP_SW:   st <= S_MEMADR;
                        OP_RTYPE:       st <= S_EXEC;
                        OP_BEQ, OP_BNE: st <= S_BRANCH;
                        OP_J, OP_JAL:   st <= S_JUMP;
                        6'b001000, 6'b001001, 6'b001010, 6'b001011,
                        6'b001100, 6'b001101, 6'b001110, 6'b001111:
                                        st <= S_IEXEC;
                        default:        st <= S_TRAP;
                    endcase
                end
                S_MEMADR: st <= (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (mem_ready) st <= S_MEMWB;
                S_MEMWR:  if (mem_ready) st <= S_FETCH;
                S_EXEC:   st <= S_RWB;
                S_IEXEC:  st <= S_IWB;
                // MEMWB, RWB, IWB, BRANCH, JUMP, TRAP and unused codes all return to FETCH
                default:  st <= S_FETCH;
            endcase
        end
    end

    // Control decode of the current state (unused codes fall through to all-zero).
    always_comb begin
        mem_req       = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 5'b00000;
        reg_write     = 1'b0;
        reg_dst       = 2'b00;
        mem_to_reg    = 1'b0;
        illegal_op    = 1'b0;
        instr_done    = 1'b0;
        case (st)
            S_FETCH: begin
                mem_req   = 1'b1;
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = 5'b00010;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = 5'b00010;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 5'b00010;
            end
            S_MEMRD: begin
                mem_req  = 1'b1;
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_req    = 1'b1;
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
            end
            S_RWB: begin
                reg_write  = 1'b1;
                reg_dst    = 2'b01;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 5'b01001;
                pc_source     = 2'b01;
                pc_write_cond = 1'b1;
                pc_write      = ((op_q == OP_BEQ) && zero) || ((op_q == OP_BNE) && !zero);
                instr_done    = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
                if (op_q == OP_JAL) begin
                    reg_write  = 1'b1;
                    reg_dst    = 2'b10;
                    mem_to_reg = 1'b1;
                end
            end
            S_IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (op_q)
                    6'b001000: alu_op = 5'b00010; // addi
                    6'b001001: alu_op = 5'b00111; // addiu
                    6'b001010: alu_op = 5'b00101; // slti
                    6'b001011: alu_op = 5'b00110; // sltiu
                    6'b001100: alu_op = 5'b00001; // andi
                    6'b001101: alu_op = 5'b00011; // ori
                    6'b001110: alu_op = 5'b00100; // xori
                    6'b001111: alu_op = 5'b01010; // lui
                    default:   alu_op = 5'b00000;
                endcase
            end
            S_IWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_TRAP: begin
                illegal_op = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class
// through the FSM and compares states and controls against hand-derived values.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_read, mem_write, iord, ir_write;
    logic       pc_write, pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [4:0] alu_op;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic       mem_to_reg;
    logic [3:0] state;
    logic       illegal_op, instr_done;

    int checks = 0;
    int errors = 0;

    logic [5:0] iops   [8] = '{6'b001000, 6'b001001, 6'b001010, 6'b001011,
                               6'b001100, 6'b001101, 6'b001110, 6'b001111};
    logic [4:0] ialuop [8] = '{5'b00010, 5'b00111, 5'b00101, 5'b00110,
                               5'b00001, 5'b00011, 5'b00100, 5'b01010};

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .state(state), .illegal_op(illegal_op),
        .instr_done(instr_done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // advance one clock, land just after the edge
    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; opcode = 6'b0; zero = 1'b0; mem_ready = 1'b0;
        #3;
        checks++;
        if ({state, mem_req, mem_read, iord, ir_write, pc_write, alu_src_a, alu_src_b, alu_op}
            !== {4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 5'b00010}) begin
            errors++;
            $display("FAIL reset_decode: state=%0d req=%b rd=%b iord=%b irw=%b pcw=%b srca=%b srcb=%b aluop=%b",
                     state, mem_req, mem_read, iord, ir_write, pc_write, alu_src_a, alu_src_b, alu_op);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if ({state, ir_write, reg_write, mem_write} !== {4'd0, 3'b000}) begin
            errors++;
            $display("FAIL reset_release: state=%0d irw=%b rw=%b mw=%b expected 0,0,0,0",
                     state, ir_write, reg_write, mem_write);
        end
    endtask

    task automatic test_lw;
        logic [3:0] exp_st [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        int done_cnt = 0;
        opcode = 6'b100011; mem_ready = 1'b1;
        #1;
        checks++;
        if ({state, ir_write, pc_write, pc_source} !== {4'd0, 1'b1, 1'b1, 2'b00}) begin
            errors++;
            $display("FAIL lw_fetch: state=%0d irw=%b pcw=%b pcsrc=%b expected 0,1,1,00",
                     state, ir_write, pc_write, pc_source);
        end
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (instr_done) done_cnt++;
            checks++;
            if ({state, reg_write} !== {exp_st[i], exp_st[i] == 4'd4}) begin
                errors++;
                $display("FAIL lw_step%0d: state=%0d rw=%b expected state=%0d", i, state, reg_write, exp_st[i]);
            end
            if (exp_st[i] == 4'd3) begin
                checks++;
                if ({mem_req, mem_read, iord, mem_write} !== 4'b1110) begin
                    errors++;
                    $display("FAIL lw_memrd: req/rd/iord/wr=%b%b%b%b expected 1110", mem_req, mem_read, iord, mem_write);
                end
            end
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL lw_instr_done_count: got %0d expected 1", done_cnt);
        end
    endtask

    task automatic test_fetch_wait;
        opcode = 6'b000000; mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({state, mem_req, mem_read, iord, ir_write, pc_write} !== {4'd0, 5'b11000}) begin
                errors++;
                $display("FAIL fetch_wait%0d: state=%0d req=%b rd=%b iord=%b irw=%b pcw=%b",
                         i, state, mem_req, mem_read, iord, ir_write, pc_write);
            end
            cyc();
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({state, mem_req, ir_write, pc_write} !== {4'd0, 3'b111}) begin
            errors++;
            $display("FAIL fetch_ready: state=%0d req=%b irw=%b pcw=%b expected 0,1,1,1",
                     state, mem_req, ir_write, pc_write);
        end
        // R-type continues: DECODE, EXEC, RWB, FETCH
        cyc();
        checks++;
        if ({state, alu_src_a, alu_src_b, alu_op} !== {4'd1, 1'b0, 2'b11, 5'b00010}) begin
            errors++;
            $display("FAIL decode_ctrl: state=%0d srca=%b srcb=%b aluop=%b", state, alu_src_a, alu_src_b, alu_op);
        end
        cyc();
        checks++;
        if ({state, alu_src_a, alu_src_b, alu_op, reg_write} !== {4'd6, 1'b1, 2'b00, 5'b00000, 1'b0}) begin
            errors++;
            $display("FAIL exec_ctrl: state=%0d srca=%b srcb=%b aluop=%b rw=%b",
                     state, alu_src_a, alu_src_b, alu_op, reg_write);
        end
        cyc();
        checks++;
        if ({state, reg_write, reg_dst, mem_to_reg, instr_done} !== {4'd7, 1'b1, 2'b01, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL rwb_ctrl: state=%0d rw=%b dst=%b m2r=%b done=%b",
                     state, reg_write, reg_dst, mem_to_reg, instr_done);
        end
        cyc();
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL rtype_return: state=%0d expected 0", state);
        end
    endtask

    task automatic test_branch;
        // beq taken
        opcode = 6'b000100; zero = 1'b1; mem_ready = 1'b1;
        cyc(); cyc();
        checks++;
        if ({state, pc_write, pc_write_cond, pc_source, alu_op, alu_src_a, instr_done}
            !== {4'd8, 1'b1, 1'b1, 2'b01, 5'b01001, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL beq_taken: state=%0d pcw=%b pcwc=%b pcsrc=%b aluop=%b srca=%b done=%b",
                     state, pc_write, pc_write_cond, pc_source, alu_op, alu_src_a, instr_done);
        end
        cyc();
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL beq_return: state=%0d expected 0", state);
        end
        // bne with zero=1: not taken
        opcode = 6'b000101;
        cyc(); cyc();
        checks++;
        if ({state, pc_write, pc_write_cond} !== {4'd8, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL bne_not_taken: state=%0d pcw=%b pcwc=%b expected 8,0,1", state, pc_write, pc_write_cond);
        end
        // bne with zero=0 in the same cycle flips the PC write
        zero = 1'b0;
        #1;
        checks++;
        if (pc_write !== 1'b1) begin
            errors++;
            $display("FAIL bne_taken: pcw=%b expected 1", pc_write);
        end
        cyc();
        // beq with zero=0: not taken
        opcode = 6'b000100;
        cyc(); cyc();
        checks++;
        if ({state, pc_write} !== {4'd8, 1'b0}) begin
            errors++;
            $display("FAIL beq_not_taken: state=%0d pcw=%b expected 8,0", state, pc_write);
        end
        cyc();
    endtask

    task automatic test_trap;
        opcode = 6'b111111; mem_ready = 1'b1;
        cyc();
        checks++;
        if ({state, reg_write, mem_write, pc_write, illegal_op} !== {4'd1, 4'b0000}) begin
            errors++;
            $display("FAIL trap_decode: state=%0d rw=%b mw=%b pcw=%b ill=%b", state, reg_write, mem_write, pc_write, illegal_op);
        end
        cyc();
        checks++;
        if ({state, reg_write, mem_write, pc_write, illegal_op, instr_done} !== {4'd12, 5'b00010}) begin
            errors++;
            $display("FAIL trap_state: state=%0d rw=%b mw=%b pcw=%b ill=%b done=%b",
                     state, reg_write, mem_write, pc_write, illegal_op, instr_done);
        end
        cyc();
        checks++;
        if ({state, illegal_op} !== {4'd0, 1'b0}) begin
            errors++;
            $display("FAIL trap_return: state=%0d ill=%b expected 0,0", state, illegal_op);
        end
    endtask

    task automatic test_jump;
        opcode = 6'b000011; mem_ready = 1'b1;
        cyc(); cyc();
        checks++;
        if ({state, pc_write, pc_source, reg_write, reg_dst, mem_to_reg, instr_done}
            !== {4'd9, 1'b1, 2'b10, 1'b1, 2'b10, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL jal: state=%0d pcw=%b pcsrc=%b rw=%b dst=%b m2r=%b done=%b",
                     state, pc_write, pc_source, reg_write, reg_dst, mem_to_reg, instr_done);
        end
        cyc();
        opcode = 6'b000010;
        cyc(); cyc();
        checks++;
        if ({state, pc_write, pc_source, reg_write, reg_dst} !== {4'd9, 1'b1, 2'b10, 1'b0, 2'b00}) begin
            errors++;
            $display("FAIL j: state=%0d pcw=%b pcsrc=%b rw=%b dst=%b", state, pc_write, pc_source, reg_write, reg_dst);
        end
        cyc();
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL jump_return: state=%0d expected 0", state);
        end
    endtask

    task automatic test_iexec;
        mem_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            opcode = iops[k];
            cyc(); cyc();
            checks++;
            if ({state, alu_src_a, alu_src_b, alu_op} !== {4'd10, 1'b1, 2'b10, ialuop[k]}) begin
                errors++;
                $display("FAIL iexec_op%b: state=%0d srca=%b srcb=%b aluop=%b expected aluop=%b",
                         iops[k], state, alu_src_a, alu_src_b, alu_op, ialuop[k]);
            end
            cyc();
            checks++;
            if ({state, reg_write, reg_dst, mem_to_reg, instr_done} !== {4'd11, 1'b1, 2'b00, 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL iwb_op%b: state=%0d rw=%b dst=%b m2r=%b done=%b",
                         iops[k], state, reg_write, reg_dst, mem_to_reg, instr_done);
            end
            cyc();
        end
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL iexec_return: state=%0d expected 0", state);
        end
    endtask

    task automatic test_sw;
        opcode = 6'b101011; mem_ready = 1'b1;
        cyc(); cyc();
        checks++;
        if ({state, alu_src_a, alu_src_b, alu_op} !== {4'd2, 1'b1, 2'b10, 5'b00010}) begin
            errors++;
            $display("FAIL sw_memadr: state=%0d srca=%b srcb=%b aluop=%b", state, alu_src_a, alu_src_b, alu_op);
        end
        mem_ready = 1'b0;
        cyc();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({state, mem_req, mem_write, iord, mem_read, instr_done} !== {4'd5, 5'b11100}) begin
                errors++;
                $display("FAIL sw_wait%0d: state=%0d req=%b wr=%b iord=%b rd=%b done=%b",
                         i, state, mem_req, mem_write, iord, mem_read, instr_done);
            end
            cyc();
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({state, instr_done} !== {4'd5, 1'b1}) begin
            errors++;
            $display("FAIL sw_done: state=%0d done=%b expected 5,1", state, instr_done);
        end
        cyc();
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL sw_return: state=%0d expected 0", state);
        end
    endtask

    task automatic test_reset_mid;
        opcode = 6'b101011; mem_ready = 1'b1;
        cyc(); cyc();
        mem_ready = 1'b0;
        cyc();
        checks++;
        if ({state, mem_write} !== {4'd5, 1'b1}) begin
            errors++;
            $display("FAIL midrst_setup: state=%0d wr=%b expected 5,1", state, mem_write);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({state, mem_write, mem_req, mem_read, iord, reg_write, pc_write} !== {4'd0, 6'b011000}) begin
            errors++;
            $display("FAIL midrst_async: state=%0d wr=%b req=%b rd=%b iord=%b rw=%b pcw=%b",
                     state, mem_write, mem_req, mem_read, iord, reg_write, pc_write);
        end
        #2;
        rst_n = 1'b1;
        cyc();
        checks++;
        if ({state, mem_write, ir_write} !== {4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midrst_restart: state=%0d wr=%b irw=%b expected 0,0,0", state, mem_write, ir_write);
        end
        mem_ready = 1'b1;
        cyc();
        checks++;
        if (state !== 4'd1) begin
            errors++;
            $display("FAIL midrst_refetch: state=%0d expected 1", state);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_fetch_wait();
        test_branch();
        test_trap();
        test_jump();
        test_iexec();
        test_sw();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
